// File: rtl/attn_score_buf.sv
// Attention score row buffer: scales one row of Q.K scores, tracks the row max, then streams max-subtracted scores.
// Optional causal masking is enabled by defining ATTN_SCORE_CAUSAL_MASK_EN.
module attn_score_buf #(
  parameter int DATA_WIDTH  = 16,
  parameter int SEQ_LEN     = 16,
  parameter int ADDR_WIDTH  = 4,
  parameter int SCALE_SHIFT = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
`ifdef ATTN_SCORE_CAUSAL_MASK_EN
  input  logic [ADDR_WIDTH-1:0] mask_len,
`endif
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic [DATA_WIDTH-1:0] row_max,
  output logic                  busy
);

  typedef enum logic {S_FILL, S_DRAIN} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(SEQ_LEN - 1);
  localparam logic [DATA_WIDTH-1:0] SAT_MIN  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] SAT_MAX  = {1'b0, {(DATA_WIDTH-1){1'b1}}};

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   wr_cnt;
  logic [ADDR_WIDTH-1:0]   rd_cnt;
  logic [DATA_WIDTH-1:0]   mem [SEQ_LEN];

  logic                    accept;
  logic                    load_first;
  logic                    wr_incl;
  logic [DATA_WIDTH-1:0]   scaled;
  logic [DATA_WIDTH-1:0]   max_next;
  logic [DATA_WIDTH-1:0]   max_use;
  logic [ADDR_WIDTH-1:0]   rd_next;
  logic [DATA_WIDTH-1:0]   elem;
  logic [DATA_WIDTH:0]     diff;
  logic [DATA_WIDTH-1:0]   elem_out;

  assign in_ready   = (state == S_FILL);
  assign accept     = in_valid && in_ready;
  assign load_first = accept && (wr_cnt == LAST_IDX);
  assign scaled     = DATA_WIDTH'($signed(in_data) >>> SCALE_SHIFT);

`ifdef ATTN_SCORE_CAUSAL_MASK_EN
  logic [ADDR_WIDTH-1:0] mask_q;
  logic                  rd_masked;
  // Index 0 is always unmasked, so the live mask_len is only needed to seed mask_q.
  assign wr_incl   = (wr_cnt <= mask_q);
  assign rd_masked = (rd_next > mask_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask_q <= '0;
    end else if (accept && (wr_cnt == '0)) begin
      mask_q <= mask_len;
    end
  end
`else
  logic rd_masked;
  assign wr_incl   = 1'b1;
  assign rd_masked = 1'b0;
`endif

  // The first element of a row never compares against a stale max.
  assign max_next = (wr_cnt == '0) ? scaled :
                    (wr_incl && ($signed(scaled) > $signed(row_max))) ? scaled : row_max;

  // The first output is loaded on the final accept, so it must see that accept's max update.
  assign max_use  = load_first ? max_next : row_max;
  assign rd_next  = load_first ? '0 : rd_cnt + 1'b1;
  assign elem     = mem[rd_next];
  assign diff     = {elem[DATA_WIDTH-1], elem} - {max_use[DATA_WIDTH-1], max_use};

  always_comb begin
    elem_out = diff[DATA_WIDTH-1:0];
    if (diff[DATA_WIDTH] != diff[DATA_WIDTH-1]) begin
      elem_out = diff[DATA_WIDTH] ? SAT_MIN : SAT_MAX;
    end
    if (rd_masked) begin
      elem_out = SAT_MIN;
    end
  end

  // NOTE: the score buffer has no reset; every entry read in DRAIN was written earlier in the same row.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_cnt] <= scaled;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_FILL;
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      row_max   <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        S_FILL: begin
          if (accept) begin
            row_max <= max_next;
            if (load_first) begin
              wr_cnt    <= '0;
              rd_cnt    <= '0;
              state     <= S_DRAIN;
              busy      <= 1'b1;
              out_valid <= 1'b1;
              out_data  <= elem_out;
              out_last  <= 1'b0;
            end else begin
              wr_cnt <= wr_cnt + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (out_valid && out_ready) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              rd_cnt    <= '0;
              busy      <= 1'b0;
              state     <= S_FILL;
            end else begin
              rd_cnt   <= rd_next;
              out_data <= elem_out;
              out_last <= (rd_next == LAST_IDX);
            end
          end
        end
        default: state <= S_FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_attn_score_buf.sv
// Directed bench for attn_score_buf: a SEQ_LEN=4/shift-3 instance and a SEQ_LEN=2/shift-0 instance.
module tb_attn_score_buf;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic               a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last, a_busy;
  logic signed [15:0] a_in_data, a_out_data, a_row_max;
  logic               b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last, b_busy;
  logic signed [15:0] b_in_data, b_out_data, b_row_max;
`ifdef ATTN_SCORE_CAUSAL_MASK_EN
  logic [1:0] a_mask_len;
  logic [0:0] b_mask_len;
`endif

  attn_score_buf #(.DATA_WIDTH(16), .SEQ_LEN(4), .ADDR_WIDTH(2), .SCALE_SHIFT(3)) dut_a (
    .clk(clk), .reset(reset),
    .in_valid(a_in_valid), .in_data(a_in_data), .in_ready(a_in_ready),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
`ifdef ATTN_SCORE_CAUSAL_MASK_EN
    .mask_len(a_mask_len),
`endif
    .out_data(a_out_data), .out_last(a_out_last), .row_max(a_row_max), .busy(a_busy)
  );

  attn_score_buf #(.DATA_WIDTH(16), .SEQ_LEN(2), .ADDR_WIDTH(1), .SCALE_SHIFT(0)) dut_b (
    .clk(clk), .reset(reset),
    .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
`ifdef ATTN_SCORE_CAUSAL_MASK_EN
    .mask_len(b_mask_len),
`endif
    .out_data(b_out_data), .out_last(b_out_last), .row_max(b_row_max), .busy(b_busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic push_a(input logic signed [15:0] d);
    check("a_in_ready", a_in_ready, 1);
    a_in_valid = 1'b1;
    a_in_data  = d;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
  endtask

  task automatic pop_a(input string tag, input logic signed [15:0] d, input logic last);
    a_out_ready = 1'b1;
    check({tag, "_valid"}, a_out_valid, 1);
    check({tag, "_data"},  a_out_data, d);
    check({tag, "_last"},  a_out_last, last);
    @(posedge clk); #1;
  endtask

  task automatic push_b(input logic signed [15:0] d);
    check("b_in_ready", b_in_ready, 1);
    b_in_valid = 1'b1;
    b_in_data  = d;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
  endtask

  task automatic pop_b(input string tag, input logic signed [15:0] d, input logic last);
    b_out_ready = 1'b1;
    check({tag, "_valid"}, b_out_valid, 1);
    check({tag, "_data"},  b_out_data, d);
    check({tag, "_last"},  b_out_last, last);
    @(posedge clk); #1;
  endtask

  task automatic row_done_a(input string tag, input logic signed [15:0] max_exp);
    check({tag, "_done_valid"}, a_out_valid, 0);
    check({tag, "_done_ready"}, a_in_ready, 1);
    check({tag, "_done_busy"},  a_busy, 0);
    check({tag, "_done_max"},   a_row_max, max_exp);
  endtask

  task automatic row_start_a(input string tag, input logic signed [15:0] max_exp);
    check({tag, "_lat_valid"}, a_out_valid, 1);
    check({tag, "_busy"},      a_busy, 1);
    check({tag, "_in_ready"},  a_in_ready, 0);
    check({tag, "_row_max"},   a_row_max, max_exp);
  endtask

  initial begin
    reset = 1'b1;
    a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
`ifdef ATTN_SCORE_CAUSAL_MASK_EN
    a_mask_len = 2'd3;
    b_mask_len = 1'b1;
`endif
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    check("rst_out_valid", a_out_valid, 0);
    check("rst_in_ready",  a_in_ready, 1);
    check("rst_out_data",  a_out_data, 0);
    check("rst_out_last",  a_out_last, 0);
    check("rst_row_max",   a_row_max, 0);
    check("rst_busy",      a_busy, 0);

    // Basic row: scaled 10,2,-1,5
    push_a(16'sd80); push_a(16'sd16); push_a(-16'sd8); push_a(16'sd40);
    row_start_a("r1", 16'sd10);
    pop_a("r1_o0", 16'sd0, 0);
    pop_a("r1_o1", -16'sd8, 0);
    pop_a("r1_o2", -16'sd11, 0);
    pop_a("r1_o3", -16'sd5, 1);
    row_done_a("r1", 16'sd10);

    // All-negative row: max must be -2, not 0
    push_a(-16'sd16); push_a(-16'sd16); push_a(-16'sd16); push_a(-16'sd16);
    row_start_a("neg", -16'sd2);
    for (int i = 0; i < 4; i++) pop_a($sformatf("neg_o%0d", i), 16'sd0, (i == 3));
    row_done_a("neg", -16'sd2);

    // Backpressure after first transfer, with ignored input traffic
    a_out_ready = 1'b0;
    push_a(16'sd80); push_a(16'sd16); push_a(-16'sd8); push_a(16'sd40);
    pop_a("bp_o0", 16'sd0, 0);
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    a_in_data   = 16'sd999;
    for (int i = 0; i < 3; i++) begin
      check("bp_hold_valid", a_out_valid, 1);
      check("bp_hold_data",  a_out_data, -16'sd8);
      check("bp_hold_last",  a_out_last, 0);
      check("bp_in_ready",   a_in_ready, 0);
      @(posedge clk); #1;
    end
    a_in_valid = 1'b0;
    check("bp_row_max", a_row_max, 16'sd10);
    pop_a("bp_o1", -16'sd8, 0);
    pop_a("bp_o2", -16'sd11, 0);
    pop_a("bp_o3", -16'sd5, 1);
    row_done_a("bp", 16'sd10);

    // Reset mid-DRAIN after two outputs
    push_a(16'sd80); push_a(16'sd16); push_a(-16'sd8); push_a(16'sd40);
    pop_a("rs_o0", 16'sd0, 0);
    pop_a("rs_o1", -16'sd8, 0);
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    check("rs_out_valid", a_out_valid, 0);
    check("rs_in_ready",  a_in_ready, 1);
    check("rs_busy",      a_busy, 0);
    @(posedge clk); #1;
    push_a(16'sd8); push_a(16'sd8); push_a(16'sd8); push_a(16'sd8);
    row_start_a("rs2", 16'sd1);
    for (int i = 0; i < 4; i++) pop_a($sformatf("rs2_o%0d", i), 16'sd0, (i == 3));
    row_done_a("rs2", 16'sd1);

    // Saturation on the SEQ_LEN=2, unscaled instance
    push_b(16'sh7FFF); push_b(16'sh8000);
    check("sat_lat_valid", b_out_valid, 1);
    check("sat_row_max",   b_row_max, 16'sd32767);
    check("sat_busy",      b_busy, 1);
    pop_b("sat_o0", 16'sd0, 0);
    pop_b("sat_o1", -16'sd32768, 1);
    check("sat_done_valid", b_out_valid, 0);
    check("sat_done_ready", b_in_ready, 1);

`ifdef ATTN_SCORE_CAUSAL_MASK_EN
    // Causal mask: indices above 1 excluded from max and forced to minimum
    a_mask_len = 2'd1;
    push_a(16'sd8);
    a_mask_len = 2'd3;
    push_a(16'sd800); push_a(16'sd16); push_a(16'sd16);
    row_start_a("msk", 16'sd100);
    pop_a("msk_o0", -16'sd99, 0);
    pop_a("msk_o1", 16'sd0, 0);
    pop_a("msk_o2", -16'sd32768, 0);
    pop_a("msk_o3", -16'sd32768, 1);
    row_done_a("msk", 16'sd100);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
